// File: rtl/eac_group_combine.sv
// Two-stage end-around-carry combiner: S1 captures the group results and the
// chain carry-out, S2 resolves group carries with that carry fed back in.
module eac_group_combine #(
    parameter int GRP_WIDTH = 4,
    parameter int NUM_GRPS  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [GRP_WIDTH*NUM_GRPS-1:0] grp_s,
    input  logic [GRP_WIDTH*NUM_GRPS-1:0] grp_s1,
    input  logic [NUM_GRPS-1:0]           grp_gg,
    input  logic [NUM_GRPS-1:0]           grp_gp,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [GRP_WIDTH*NUM_GRPS-1:0] sum,
    output logic                          eac,
    output logic                          neg_zero
);

    localparam int W = GRP_WIDTH * NUM_GRPS;

    logic                s1_valid;
    logic [W-1:0]        s1_s;
    logic [W-1:0]        s1_s1;
    logic [NUM_GRPS-1:0] s1_gg;
    logic [NUM_GRPS-1:0] s1_gp;
    logic                s1_eac;

    logic         s1_load;
    logic         s2_load;
    logic         chain_out;
    logic         carry;
    logic [W-1:0] sel_sum;

    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign s1_load  = in_valid && in_ready;

    // Group-level carry chain with carry-in 0; its carry-out is the end-around carry.
    always_comb begin
        chain_out = 1'b0;
        for (int k = 0; k < NUM_GRPS; k++) begin
            chain_out = grp_gg[k] | (grp_gp[k] & chain_out);
        end
    end

    always_comb begin
        carry   = s1_eac;
        sel_sum = '0;
        for (int k = 0; k < NUM_GRPS; k++) begin
            sel_sum[k*GRP_WIDTH +: GRP_WIDTH] = carry ? s1_s1[k*GRP_WIDTH +: GRP_WIDTH]
                                                      : s1_s[k*GRP_WIDTH +: GRP_WIDTH];
            carry = s1_gg[k] | (s1_gp[k] & carry);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_s     <= '0;
            s1_s1    <= '0;
            s1_gg    <= '0;
            s1_gp    <= '0;
            s1_eac   <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_s     <= grp_s;
                s1_s1    <= grp_s1;
                s1_gg    <= grp_gg;
                s1_gp    <= grp_gp;
                s1_eac   <= chain_out;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // A stalled output holds its data because S2 only loads when it is free or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            eac       <= 1'b0;
            neg_zero  <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid <= 1'b1;
                sum       <= sel_sum;
                eac       <= s1_eac;
                neg_zero  <= &sel_sum;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eac_group_combine.sv
// Randomized bench for eac_group_combine: ones'-complement arithmetic model and
// an in-flight queue used as the scoreboard for ordering and handshake checks.
module tb_eac_group_combine;

    localparam int GW = 4;
    localparam int NG = 4;
    localparam int W  = GW * NG;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  grp_s = '0;
    logic [W-1:0]  grp_s1 = '0;
    logic [NG-1:0] grp_gg = '0;
    logic [NG-1:0] grp_gp = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  sum;
    logic          eac;
    logic          neg_zero;

    int vectors = 0;
    int errors  = 0;

    logic [W+1:0] expq[$];
    bit           held_valid = 0;
    logic [W+1:0] held_val;

    eac_group_combine #(.GRP_WIDTH(GW), .NUM_GRPS(NG)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .grp_s(grp_s), .grp_s1(grp_s1), .grp_gg(grp_gg), .grp_gp(grp_gp),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .eac(eac), .neg_zero(neg_zero)
    );

    always #5 clk = ~clk;

    // Plain ones'-complement addition: one end-around carry, {neg_zero, eac, sum}.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]   full;
        logic [W-1:0] r;
        full = {1'b0, a} + {1'b0, b};
        r    = full[W-1:0] + {{(W-1){1'b0}}, full[W]};
        return {(r == {W{1'b1}}), full[W], r};
    endfunction

    task automatic drive_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [GW:0]   t0;
        logic [GW:0]   t1;
        logic [GW-1:0] ak;
        logic [GW-1:0] bk;
        for (int k = 0; k < NG; k++) begin
            ak = a[k*GW +: GW];
            bk = b[k*GW +: GW];
            t0 = {1'b0, ak} + {1'b0, bk};
            t1 = {1'b0, ak} + {1'b0, bk} + 1'b1;
            grp_s[k*GW +: GW]  = t0[GW-1:0];
            grp_s1[k*GW +: GW] = t1[GW-1:0];
            grp_gg[k]          = t0[GW];
            grp_gp[k]          = &(ak ^ bk);
        end
    endtask

    // One clock of traffic: drive at negedge, check against the scoreboard, then let the edge pass.
    task automatic step(input bit iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit ordy, output bit accepted);
        bit exp_ir;
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        drive_pair(a, b);
        #1;
        exp_ir = !(expq.size() == 2 && !ordy);
        vectors++;
        if (in_ready !== exp_ir) begin
            errors++;
            $display("[TB] FAIL in_ready: got %b expected %b (in flight %0d)", in_ready, exp_ir, expq.size());
        end
        if (expq.size() == 0) begin
            vectors++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL spurious_out: out_valid %b with nothing in flight", out_valid);
            end
        end
        if (held_valid) begin
            vectors++;
            if (out_valid !== 1'b1 || {neg_zero, eac, sum} !== held_val) begin
                errors++;
                $display("[TB] FAIL stall_hold: got v=%b %h expected v=1 %h", out_valid, {neg_zero, eac, sum}, held_val);
            end
        end
        held_valid = (out_valid === 1'b1) && !ordy;
        held_val   = {neg_zero, eac, sum};
        if (out_valid === 1'b1 && ordy && expq.size() > 0) begin
            vectors++;
            if ({neg_zero, eac, sum} !== expq[0]) begin
                errors++;
                $display("[TB] FAIL stream_out: got nz=%b eac=%b sum=%h expected %h",
                         neg_zero, eac, sum, expq[0]);
            end
            void'(expq.pop_front());
        end
        accepted = iv && (in_ready === 1'b1);
        if (accepted) expq.push_back(ref_model(a, b));
        @(posedge clk);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20 && expq.size() > 0; i++) begin
            step(0, W'($urandom), W'($urandom), 1, acc);
        end
        vectors++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: %0d results still missing, expected 0", expq.size());
            expq.delete();
        end
        held_valid = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({out_valid, neg_zero, eac, sum} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got v=%b nz=%b eac=%b sum=%h expected all 0",
                     out_valid, neg_zero, eac, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] exp_sum, input bit exp_eac, input bit exp_nz);
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive_pair(a, b);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_accept: in_ready %b expected 1", name, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_latency: out_valid %b one edge after accept, expected 0", name, out_valid);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || sum !== exp_sum || eac !== exp_eac || neg_zero !== exp_nz) begin
            errors++;
            $display("[TB] FAIL %s: got v=%b sum=%h eac=%b nz=%b expected v=1 sum=%h eac=%b nz=%b",
                     name, out_valid, sum, eac, neg_zero, exp_sum, exp_eac, exp_nz);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit           acc;
        bit           saw_block = 0;
        int           sent = 0;
        logic [W-1:0] a = W'($urandom);
        logic [W-1:0] b = W'($urandom);
        for (int cyc = 0; cyc < 100 && sent < 8; cyc++) begin
            if (expq.size() == 2 && (cyc >= 3 && cyc <= 6)) saw_block = 1;
            step(1, a, b, !(cyc >= 3 && cyc <= 6), acc);
            if (acc) begin
                sent++;
                a = W'($urandom);
                b = W'($urandom);
            end
        end
        vectors++;
        if (sent != 8 || !saw_block) begin
            errors++;
            $display("[TB] FAIL backpressure_fill: sent %0d full=%b expected 8 and 1", sent, saw_block);
        end
        drain();
    endtask

    task automatic test_random_stream();
        bit acc;
        for (int cyc = 0; cyc < 300; cyc++) begin
            step($urandom_range(0, 1) == 1, W'($urandom), W'($urandom), $urandom_range(0, 3) != 0, acc);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        bit acc;
        int got = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            step(1, W'($urandom), W'($urandom), 1, acc);
            if (acc) got++;
        end
        vectors++;
        if (got != 40) begin
            errors++;
            $display("[TB] FAIL back_to_back: accepted %0d of 40, expected 40", got);
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        bit acc;
        step(1, W'($urandom), W'($urandom), 0, acc);
        step(1, W'($urandom), W'($urandom), 0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        vectors++;
        if ({out_valid, neg_zero, eac, sum} !== '0) begin
            errors++;
            $display("[TB] FAIL midstream_reset: got v=%b nz=%b eac=%b sum=%h expected all 0",
                     out_valid, neg_zero, eac, sum);
        end
        expq.delete();
        held_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(0, W'($urandom), W'($urandom), 1, acc);
        step(1, 16'h0005, 16'hFFFD, 1, acc);
        drain();
    endtask

    initial begin
        test_reset();
        test_directed("eac_wrap",   16'h0005, 16'hFFFD, 16'h0003, 1'b1, 1'b0);
        test_directed("no_carry",   16'h1234, 16'h0101, 16'h1335, 1'b0, 1'b0);
        test_directed("neg_zero",   16'h00FF, 16'hFF00, 16'hFFFF, 1'b0, 1'b1);
        test_directed("ripple",     16'h8FFF, 16'h8001, 16'h1001, 1'b1, 1'b0);
        test_backpressure();
        test_back_to_back();
        test_random_stream();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
